trig_sched: RTL and testbench
=============================

Name: trig_sched

Overview:
- Trigger scheduler/controller for the timecounter trigger path.
- Selects one trigger source: external, CPU or internal emulator.
- Gates triggers to the spill window, which is bounded by the cyclebegin and cyclebegin/cycleend pulses. Issues one qualified trigger pulse per event, runs a request/acknowledge handshake with readout, then enforces a programmable dead time.
- Counts accepted and lost triggers per spill for the CPU status registers.

Parameters:
- CNT_W, 32, width of accepted/lost event counters (saturating)
- PER_W, 24, width of emulator period register (clk cycles)
- DEAD_W, 16, width of dead-time register (clk cycles)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- trigin  in  1  external trigger, asynchronous, level; rising edge = trigger
- trigcpu  in  1  CPU trigger, clk-synchronous single-cycle pulse
- trigsel  in  2  source: 0 external, 1 CPU, 2 emulator, 3 disabled
- emu_period  in  PER_W  emulator period; 0 = emulator off
- dead_time  in  DEAD_W  dead-time cycles after ro_ack
- cyclebegin  in  1  spill start, one-cycle pulse
- cycleend  in  1  spill end, one-cycle pulse
- ro_ack  in  1  readout acknowledge, level
- trigpulse  out  1  accepted trigger, one-cycle pulse
- ro_req  out  1  readout request, level
- busy  out  1  high in FIRE/WAIT_ACK/DEAD
- in_spill  out  1  spill window flag
- evt_cnt  out  CNT_W  accepted triggers this spill
- lost_cnt  out  CNT_W  triggers rejected while busy this spill

Behaviour:
- Reset (rst=1 at posedge): state IDLE; all outputs 0; counters, synchronizer and emulator counter cleared.
- trigin path: 2-FF synchronizer, then edge register. A rising edge produces a qualified trigger 3 clk after the first sampling edge.
- Level held high (e.g. 2000 ns) = exactly one trigger.
- trigcpu: qualified the same cycle it is sampled.
- Emulator:
  - Counter runs only when trigsel=2, in_spill=1 and emu_period!=0.
  - Fires when count = emu_period-1, then wraps to 0; period is emu_period cycles.
  - Counter clears on cyclebegin.
  - emu_period=1 gives a request every cycle.
- Only the source chosen by trigsel is qualified; trigsel=3 qualifies nothing. trigsel changes take effect the next cycle.
- in_spill: set by cyclebegin, cleared by cycleend. If both arrive in the same cycle, cyclebegin wins (new spill).
- evt_cnt and lost_cnt clear on cyclebegin. Both saturate at all-ones.
- FSM states:
  - IDLE: no spill; qualified triggers ignored and not counted. Go to ARMED on cyclebegin.
  - ARMED: on a qualified trigger, go to FIRE. On cycleend, go to IDLE. If both occur in the same cycle, cycleend wins and the trigger is dropped uncounted.
  - FIRE (1 cycle): trigpulse=1, evt_cnt++, ro_req set. Then go to WAIT_ACK.
  - WAIT_ACK: ro_req held until ro_ack=1. Then ro_req drops the same edge and the FSM goes to DEAD, loading the dead counter with dead_time.
  - DEAD: count down. At 0 go to ARMED, or to IDLE if in_spill=0. dead_time=0 gives one DEAD cycle.
- Qualified trigger in FIRE/WAIT_ACK/DEAD with in_spill=1: lost_cnt++, no pulse.
- cycleend during WAIT_ACK/DEAD: the handshake and dead time complete normally, then the FSM goes to IDLE. Readout is never abandoned.
- Trigger-to-trigpulse latency from ARMED: 1 clk (CPU/emulator), 4 clk from the trigin edge.
- Minimum trigger spacing: 3 + ack latency + dead_time cycles.

Decomposition:
- Shared package trig_pkg holds:
  - trigsel encodings: SEL_EXT=0, SEL_CPU=1, SEL_EMU=2, SEL_OFF=3
  - FSM state enum: IDLE, ARMED, FIRE, WAIT_ACK, DEAD
- Sub-module trig_emu: emulator period counter with enable/clear, one-cycle fire output.
- Synchronizer and edge detect stay inline.

Test Plan:
- Spill with external trigger: rst, cyclebegin, trigsel=0, trigin high 20 ns; ro_ack 2 clk after ro_req; dead_time=10 -> one trigpulse 4 clk after the edge, evt_cnt=1, busy for the handshake plus 11 clk, lost_cnt=0.
- Held external level: trigin held high 2000 ns -> exactly one trigpulse, evt_cnt=1.
- Emulator: trigsel=2, emu_period=100, dead_time=5, immediate ack, spill of 1000 clk -> 10 trigpulses spaced 100 clk, lost_cnt=0. With emu_period=3 -> lost_cnt>0 and evt_cnt+lost_cnt = spill triggers.
- Out-of-spill and disabled sources: trigcpu pulses before cyclebegin, and with trigsel=3 inside the spill -> no trigpulse, both counters 0. trigcpu in spill with trigsel=1 -> trigpulse next cycle.
- Spill end during readout: cycleend while in WAIT_ACK -> ro_req stays until ack, DEAD completes, state IDLE, in_spill=0. cyclebegin and cycleend in the same cycle -> in_spill=1 and counters cleared.
- Reset mid-DEAD: rst=1 -> next cycle all outputs 0, state IDLE, counters 0.

Source files
------------

// File: rtl/trig_pkg.sv
// Shared encodings for the trigger scheduler: source select values and FSM states.
package trig_pkg;

    // trigsel encodings
    localparam logic [1:0] SEL_EXT = 2'd0;
    localparam logic [1:0] SEL_CPU = 2'd1;
    localparam logic [1:0] SEL_EMU = 2'd2;
    localparam logic [1:0] SEL_OFF = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StFire,
        StWaitAck,
        StDead
    } state_e;

endpackage

// File: rtl/trig_emu.sv
// Internal trigger emulator: free-running period counter with a one-cycle fire strobe.
module trig_emu #(
    parameter int unsigned PER_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [PER_W-1:0] period,
    output logic             fire
);

    logic [PER_W-1:0] cnt_q;
    logic             active;

    // A zero period parks the counter.
    assign active = en && (period != '0);
    // >= rather than == so a period shortened mid-count recovers at once instead of wrapping.
    assign fire   = active && (cnt_q >= period - 1'b1);

    // Count while active, wrap on fire; cleared at spill start.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (active) begin
            cnt_q <= fire ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/trig_sched.sv
// Trigger scheduler: source select, spill gating, readout handshake, dead time and counters.
module trig_sched
    import trig_pkg::*;
#(
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned PER_W  = 24,
    parameter int unsigned DEAD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trigin,
    input  logic              trigcpu,
    input  logic [1:0]        trigsel,
    input  logic [PER_W-1:0]  emu_period,
    input  logic [DEAD_W-1:0] dead_time,
    input  logic              cyclebegin,
    input  logic              cycleend,
    input  logic              ro_ack,
    output logic              trigpulse,
    output logic              ro_req,
    output logic              busy,
    output logic              in_spill,
    output logic [CNT_W-1:0]  evt_cnt,
    output logic [CNT_W-1:0]  lost_cnt
);

    logic [1:0]        sel_q;
    logic              sync0_q, sync1_q, edge_q, rise_q;
    logic              emu_fire;
    logic              qual;
    logic              in_spill_d;
    logic [CNT_W-1:0]  evt_base, lost_base;
    logic [DEAD_W-1:0] dead_q;
    state_e            state_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Synchronize the async external trigger, register its rising edge and the source select.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            edge_q  <= 1'b0;
            rise_q  <= 1'b0;
            sel_q   <= SEL_EXT;
        end else begin
            sync0_q <= trigin;
            sync1_q <= sync0_q;
            edge_q  <= sync1_q;
            rise_q  <= sync1_q & ~edge_q;
            sel_q   <= trigsel;
        end
    end

    trig_emu #(
        .PER_W (PER_W)
    ) u_emu (
        .clk    (clk),
        .rst    (rst),
        .en     ((sel_q == SEL_EMU) && in_spill),
        .clr    (cyclebegin),
        .period (emu_period),
        .fire   (emu_fire)
    );

    // Qualify the selected source; cyclebegin beats cycleend for the next spill flag.
    always_comb begin
        qual = 1'b0;
        case (sel_q)
            SEL_EXT: qual = rise_q;
            SEL_CPU: qual = trigcpu;
            SEL_EMU: qual = emu_fire;
            default: qual = 1'b0;
        endcase
        in_spill_d = cyclebegin ? 1'b1 : (cycleend ? 1'b0 : in_spill);
        evt_base   = cyclebegin ? '0 : evt_cnt;
        lost_base  = cyclebegin ? '0 : lost_cnt;
    end

    // Main FSM with registered outputs and per-spill counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            trigpulse <= 1'b0;
            ro_req    <= 1'b0;
            busy      <= 1'b0;
            in_spill  <= 1'b0;
            evt_cnt   <= '0;
            lost_cnt  <= '0;
            dead_q    <= '0;
        end else begin
            in_spill  <= in_spill_d;
            trigpulse <= 1'b0;
            evt_cnt   <= evt_base;
            // Triggers arriving while readout is in progress are only counted.
            if ((state_q inside {StFire, StWaitAck, StDead}) && qual && in_spill) begin
                lost_cnt <= sat_inc(lost_base);
            end else begin
                lost_cnt <= lost_base;
            end
            case (state_q)
                StIdle: begin
                    if (cyclebegin) state_q <= StArmed;
                end
                StArmed: begin
                    // Spill end takes priority; a coincident trigger is dropped uncounted.
                    if (!in_spill_d) begin
                        state_q <= StIdle;
                    end else if (qual) begin
                        state_q   <= StFire;
                        trigpulse <= 1'b1;
                        ro_req    <= 1'b1;
                        busy      <= 1'b1;
                        evt_cnt   <= sat_inc(evt_base);
                    end
                end
                StFire: begin
                    state_q <= StWaitAck;
                end
                StWaitAck: begin
                    if (ro_ack) begin
                        ro_req  <= 1'b0;
                        dead_q  <= dead_time;
                        state_q <= StDead;
                    end
                end
                StDead: begin
                    if (dead_q == '0) begin
                        busy    <= 1'b0;
                        state_q <= in_spill_d ? StArmed : StIdle;
                    end else begin
                        dead_q <= dead_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ro_req  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trig_sched.sv
// Directed bench for trig_sched: expected trigpulse cycles are queued as stimulus is driven
// and compared against the cycles at which pulses are observed.
module tb_trig_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        trigin, trigcpu, cyclebegin, cycleend, ro_ack;
    logic [1:0]  trigsel;
    logic [23:0] emu_period;
    logic [15:0] dead_time;
    logic        trigpulse, ro_req, busy, in_spill;
    logic [31:0] evt_cnt, lost_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ack_dly = 0;
    int req_age = 0;
    int busy_cycles = 0;
    int cb = 0;
    int seen_q[$];
    int exp_q[$];

    always #5 clk = ~clk;

    trig_sched dut (
        .clk        (clk),
        .rst        (rst),
        .trigin     (trigin),
        .trigcpu    (trigcpu),
        .trigsel    (trigsel),
        .emu_period (emu_period),
        .dead_time  (dead_time),
        .cyclebegin (cyclebegin),
        .cycleend   (cycleend),
        .ro_ack     (ro_ack),
        .trigpulse  (trigpulse),
        .ro_req     (ro_req),
        .busy       (busy),
        .in_spill   (in_spill),
        .evt_cnt    (evt_cnt),
        .lost_cnt   (lost_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: pulse inputs last one edge; outputs sampled and readout acked at negedge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        cyclebegin = 1'b0;
        cycleend   = 1'b0;
        trigcpu    = 1'b0;
        @(negedge clk);
        if (trigpulse === 1'b1) seen_q.push_back(cyc);
        if (busy === 1'b1) busy_cycles++;
        if (ro_req !== 1'b1) begin
            ro_ack  = 1'b0;
            req_age = 0;
        end else begin
            if (req_age >= ack_dly) ro_ack = 1'b1;
            req_age++;
        end
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic drain(input string tag);
        check({tag, "_npulse"}, seen_q.size(), exp_q.size());
        while (seen_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_pulse_cyc"}, seen_q.pop_front(), exp_q.pop_front());
        seen_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; trigin = 1'b0; trigcpu = 1'b0; cyclebegin = 1'b0; cycleend = 1'b0;
        ro_ack = 1'b0; trigsel = 2'd3; emu_period = '0; dead_time = '0;
        repeat (3) tick();
        check("rst_outs", {trigpulse, ro_req, busy, in_spill}, 0);
        check("rst_evt", evt_cnt, 0);
        check("rst_lost", lost_cnt, 0);
        rst = 1'b0;
        tick();

        // CPU trigger before any spill is ignored.
        trigsel = 2'd1;
        tick();
        trigcpu = 1'b1;
        tick();
        repeat (3) tick();
        check("nospill_evt", evt_cnt, 0);
        drain("nospill");

        // External 20 ns trigger: pulse on the 4th edge after the raise.
        trigsel = 2'd0; dead_time = 16'd10; ack_dly = 2;
        cyclebegin = 1'b1;
        tick();
        check("ext_in_spill", in_spill, 1);
        busy_cycles = 0;
        trigin = 1'b1;
        exp_q.push_back(cyc + 4);
        tick();
        tick();
        trigin = 1'b0;
        repeat (6) tick();
        wait_idle("ext", 60);
        drain("ext");
        check("ext_evt", evt_cnt, 1);
        check("ext_lost", lost_cnt, 0);
        // FIRE + max(1, ack delay) WAIT_ACK cycles + dead_time+1 DEAD cycles.
        check("ext_busy", busy_cycles, 1 + 2 + 11);

        // Level held 2000 ns gives exactly one trigger.
        cyclebegin = 1'b1;
        tick();
        trigin = 1'b1;
        exp_q.push_back(cyc + 4);
        repeat (200) tick();
        trigin = 1'b0;
        repeat (5) tick();
        wait_idle("held", 60);
        drain("held");
        check("held_evt", evt_cnt, 1);
        check("held_lost", lost_cnt, 0);

        // Disabled source in spill qualifies nothing.
        trigsel = 2'd3;
        tick();
        cyclebegin = 1'b1;
        tick();
        trigcpu = 1'b1;
        tick();
        repeat (3) tick();
        check("off_evt", evt_cnt, 0);
        check("off_lost", lost_cnt, 0);
        drain("off");

        // CPU trigger in spill: pulse next cycle; a second one during WAIT_ACK is lost.
        trigsel = 2'd1;
        tick();
        trigcpu = 1'b1;
        exp_q.push_back(cyc + 1);
        tick();
        tick();
        tick();
        trigcpu = 1'b1;
        tick();
        wait_idle("cpu", 60);
        drain("cpu");
        check("cpu_evt", evt_cnt, 1);
        check("cpu_lost", lost_cnt, 1);

        // Emulator, period 100, dead 5, immediate ack: 10 triggers, none lost.
        cycleend = 1'b1;
        tick();
        trigsel = 2'd2; emu_period = 24'd100; dead_time = 16'd5; ack_dly = 0;
        repeat (2) tick();
        cyclebegin = 1'b1;
        tick();
        cb = cyc;
        for (int j = 1; j <= 10; j++) exp_q.push_back(cb + 100 * j);
        while (cyc < cb + 1004) tick();
        cycleend = 1'b1;
        tick();
        wait_idle("emu100", 60);
        repeat (3) tick();
        drain("emu100");
        check("emu100_evt", evt_cnt, 10);
        check("emu100_lost", lost_cnt, 0);
        check("emu100_in_spill", in_spill, 0);

        // Period 3: each readout occupies 8 cycles, so triggers land at cb+3+9j and the two
        // requests inside each busy window are lost. Spill edges cb+3..cb+300 carry 100 requests.
        emu_period = 24'd3;
        tick();
        cyclebegin = 1'b1;
        tick();
        cb = cyc;
        for (int j = 0; j < 34; j++) exp_q.push_back(cb + 3 + 9 * j);
        while (cyc < cb + 300) tick();
        cycleend = 1'b1;
        tick();
        wait_idle("emu3", 60);
        repeat (3) tick();
        drain("emu3");
        check("emu3_lost_nz", lost_cnt > 0, 1);
        check("emu3_sum", evt_cnt + lost_cnt, 100);
        check("emu3_evt", evt_cnt, 34);
        check("emu3_lost", lost_cnt, 66);

        // Spill end while waiting for ack: readout and dead time still complete.
        trigsel = 2'd1; dead_time = 16'd4; ack_dly = 5;
        tick();
        cyclebegin = 1'b1;
        tick();
        busy_cycles = 0;
        trigcpu = 1'b1;
        exp_q.push_back(cyc + 1);
        tick();
        tick();
        cycleend = 1'b1;
        tick();
        check("end_ro_req_held", ro_req, 1);
        check("end_in_spill", in_spill, 0);
        wait_idle("end", 60);
        check("end_busy", busy_cycles, 1 + 5 + 5);
        check("end_ro_req", ro_req, 0);
        trigcpu = 1'b1;
        tick();
        repeat (3) tick();
        drain("end");
        check("end_evt", evt_cnt, 1);
        check("end_lost", lost_cnt, 0);

        // Coincident begin/end opens a new spill and clears counters.
        cyclebegin = 1'b1;
        cycleend = 1'b1;
        tick();
        check("both_in_spill", in_spill, 1);
        check("both_evt", evt_cnt, 0);
        check("both_lost", lost_cnt, 0);

        // Reset in the middle of DEAD.
        dead_time = 16'd20; ack_dly = 0;
        trigcpu = 1'b1;
        exp_q.push_back(cyc + 1);
        repeat (5) tick();
        check("rdead_busy", busy, 1);
        rst = 1'b1;
        tick();
        check("rdead_outs", {trigpulse, ro_req, busy, in_spill}, 0);
        check("rdead_evt", evt_cnt, 0);
        check("rdead_lost", lost_cnt, 0);
        rst = 1'b0;
        tick();
        drain("rdead");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
